timebase_ctrl: RTL and testbench

TIMEBASE_CTRL -- requirements
Module: timebase_ctrl

---
 rtl/timebase_ctrl.sv | 176 +++++++++++++++++
 tb/tb_timebase_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timebase_ctrl.sv
// Programmable half-period timebase with square-wave output and graceful stop.
// Define TIMEBASE_BURST_EN to enable the burst tick limit and done pulse.
module timebase_ctrl #(
  parameter int CNT_W       = 27,
  parameter int DEFAULT_DIV = 2500000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_wr,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [7:0]       cfg_burst,
  output logic             cfg_ack,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             tick,
  output logic             hzSig,
  output logic [7:0]       tick_count,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] sdiv_q, sdiv_d;
  logic [CNT_W-1:0] lim;
  logic [7:0]       tcnt_q, tcnt_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             hz_q, hz_d;
  logic             ack_q, ack_d;
  logic             done_q, done_d;
  logic             fin_q, fin_d;
  logic             running, wrap, go, hit;

`ifdef TIMEBASE_BURST_EN
  logic [7:0] burst_q, burst_d;
  logic [7:0] sburst_q, sburst_d;
`else
  logic unused_burst;
  assign unused_burst = ^cfg_burst;
`endif

  always_comb begin
    lim     = (div_q == '0) ? '0 : div_q - CNT_W'(1);
    running = (state_q != IDLE);
    wrap    = running && (cnt_q == lim);
    go      = start && !stop;
`ifdef TIMEBASE_BURST_EN
    hit     = wrap && (state_q == RUN) && (burst_q != 8'd0) &&
              ((tcnt_q + 8'd1) == burst_q);
`else
    hit     = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    sdiv_d  = sdiv_q;
    tcnt_d  = tcnt_q;
    pend_d  = pend_q;
    tick_d  = 1'b0;
    hz_d    = hz_q;
    ack_d   = cfg_wr;
    done_d  = hit;
    fin_d   = 1'b0;
`ifdef TIMEBASE_BURST_EN
    burst_d  = burst_q;
    sburst_d = sburst_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        hz_d  = 1'b0;
        if (go) begin
          state_d = RUN;
          tcnt_d  = 8'd0;
        end
      end
      RUN, STOPPING: begin
        // fin_q marks the 1->0 tick seen last cycle while stopping
        if (state_q == STOPPING && fin_q && !go) begin
          state_d = IDLE;
          cnt_d   = '0;
          hz_d    = 1'b0;
        end else begin
          cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
          if (wrap) begin
            tick_d = 1'b1;
            hz_d   = ~hz_q;
            tcnt_d = tcnt_q + 8'd1;
          end
          if (state_q == RUN) begin
            if (stop || hit) state_d = STOPPING;
          end else begin
            if (go) state_d = RUN;
            fin_d = wrap && hz_q && !go;
          end
        end
        if (pend_q && (wrap || state_d == IDLE)) begin
          div_d  = sdiv_q;
          pend_d = 1'b0;
`ifdef TIMEBASE_BURST_EN
          burst_d = sburst_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    if (cfg_wr) begin
      sdiv_d = cfg_div;
`ifdef TIMEBASE_BURST_EN
      sburst_d = cfg_burst;
`endif
      if (state_q == IDLE || state_d == IDLE) begin
        div_d  = cfg_div;
        pend_d = 1'b0;
`ifdef TIMEBASE_BURST_EN
        burst_d = cfg_burst;
`endif
      end else begin
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= DIV_RST;
      sdiv_q  <= DIV_RST;
      tcnt_q  <= 8'd0;
      pend_q  <= 1'b0;
      tick_q  <= 1'b0;
      hz_q    <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      fin_q   <= 1'b0;
`ifdef TIMEBASE_BURST_EN
      burst_q  <= 8'd0;
      sburst_q <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      sdiv_q  <= sdiv_d;
      tcnt_q  <= tcnt_d;
      pend_q  <= pend_d;
      tick_q  <= tick_d;
      hz_q    <= hz_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      fin_q   <= fin_d;
`ifdef TIMEBASE_BURST_EN
      burst_q  <= burst_d;
      sburst_q <= sburst_d;
`endif
    end
  end

  assign cfg_ack    = ack_q;
  assign busy       = (state_q != IDLE);
  assign tick       = tick_q;
  assign hzSig      = hz_q;
  assign tick_count = tcnt_q;
  assign done       = done_q;

endmodule

// File: tb/tb_timebase_ctrl.sv
// Scoreboard bench for timebase_ctrl with DEFAULT_DIV=4.
// Expected tick/ack/done events are queued by cycle; a monitor pops them.
module tb_timebase_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_wr = 1'b0;
  logic [26:0] cfg_div = '0;
  logic [7:0]  cfg_burst = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        cfg_ack, busy, tick, hzSig, done;
  logic [7:0]  tick_count;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int         c;
    logic       hz;
    logic [7:0] tc;
  } ev_t;

  ev_t tq[$];
  int  aq[$];
  int  dq[$];

  timebase_ctrl #(
    .CNT_W(27),
    .DEFAULT_DIV(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cfg_wr(cfg_wr),
    .cfg_div(cfg_div),
    .cfg_burst(cfg_burst),
    .cfg_ack(cfg_ack),
    .start(start),
    .stop(stop),
    .busy(busy),
    .tick(tick),
    .hzSig(hzSig),
    .tick_count(tick_count),
    .done(done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic exp_tick(input int c, input logic h, input int n);
    ev_t e;
    e.c  = c;
    e.hz = h;
    e.tc = 8'(n);
    tq.push_back(e);
  endtask

  always @(negedge clock) begin
    if (tick) begin : mon_tick
      ev_t e;
      if (tq.size() == 0) begin
        chk("tick_unexpected", cyc, -1);
      end else begin
        e = tq.pop_front();
        chk("tick_cycle", cyc, e.c);
        chk("tick_hz", int'(hzSig), int'(e.hz));
        chk("tick_count", int'(tick_count), int'(e.tc));
      end
    end
    if (cfg_ack) begin
      if (aq.size() == 0) chk("ack_unexpected", cyc, -1);
      else chk("ack_cycle", cyc, aq.pop_front());
    end
    if (done) begin
      if (dq.size() == 0) chk("done_unexpected", cyc, -1);
      else chk("done_cycle", cyc, dq.pop_front());
    end
  end

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_tick"}, int'(tick), 0);
    chk({tag, "_hz"}, int'(hzSig), 0);
    chk({tag, "_tcnt"}, int'(tick_count), 0);
    chk({tag, "_ack"}, int'(cfg_ack), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin : stim
    int t;
    repeat (3) @(negedge clock);
    chk_idle_outputs("reset");
    reset = 1'b0;

    // basic run at default div 4, then graceful stop with hzSig=0
    @(negedge clock);
    t = cyc;
    start = 1'b1;
    exp_tick(t + 5, 1'b1, 1);
    exp_tick(t + 9, 1'b0, 2);
    exp_tick(t + 13, 1'b1, 3);
    exp_tick(t + 17, 1'b0, 4);
    exp_tick(t + 21, 1'b1, 5);
    exp_tick(t + 25, 1'b0, 6);
    @(negedge clock);
    start = 1'b0;
    chk("run_busy", int'(busy), 1);
    wait_until(t + 18);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    wait_until(t + 25);
    chk("stop_busy_last_tick", int'(busy), 1);
    @(negedge clock);
    chk("stop_busy_fall", int'(busy), 0);
    chk("stop_hz_end", int'(hzSig), 0);

    // mid-run reconfiguration, back-to-back writes, reset mid-run
    @(negedge clock);
    t = cyc;
    start = 1'b1;
    exp_tick(t + 5, 1'b1, 1);
    exp_tick(t + 9, 1'b0, 2);
    exp_tick(t + 13, 1'b1, 3);
    exp_tick(t + 19, 1'b0, 4);
    exp_tick(t + 25, 1'b1, 5);
    exp_tick(t + 31, 1'b0, 6);
    exp_tick(t + 34, 1'b1, 7);
    exp_tick(t + 37, 1'b0, 8);
    @(negedge clock);
    start = 1'b0;
    wait_until(t + 11);
    cfg_div = 27'd6;
    cfg_wr = 1'b1;
    aq.push_back(t + 12);
    @(negedge clock);
    cfg_wr = 1'b0;
    wait_until(t + 26);
    cfg_div = 27'd2;
    cfg_wr = 1'b1;
    aq.push_back(t + 27);
    @(negedge clock);
    cfg_div = 27'd3;
    aq.push_back(t + 28);
    @(negedge clock);
    cfg_wr = 1'b0;
    wait_until(t + 39);
    reset = 1'b1;
    @(negedge clock);
    chk_idle_outputs("midrun_reset");
    reset = 1'b0;

    // div back at default after reset; start+stop together in RUN
    @(negedge clock);
    start = 1'b1;
    exp_tick(t + 46, 1'b1, 1);
    exp_tick(t + 50, 1'b0, 2);
    @(negedge clock);
    start = 1'b0;
    wait_until(t + 47);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clock);
    start = 1'b0;
    stop = 1'b0;
    chk("both_run_busy", int'(busy), 1);
    wait_until(t + 51);
    chk("both_run_idle", int'(busy), 0);
    chk("both_run_hz", int'(hzSig), 0);

    // start+stop together in IDLE
    @(negedge clock);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clock);
    start = 1'b0;
    stop = 1'b0;
    chk("both_idle_busy", int'(busy), 0);
    @(negedge clock);
    chk("both_idle_busy2", int'(busy), 0);

    // div 0 behaves as 1: tick every cycle
    @(negedge clock);
    t = cyc;
    cfg_div = 27'd0;
    cfg_wr = 1'b1;
    aq.push_back(t + 1);
    @(negedge clock);
    cfg_wr = 1'b0;
    start = 1'b1;
    exp_tick(t + 3, 1'b1, 1);
    exp_tick(t + 4, 1'b0, 2);
    exp_tick(t + 5, 1'b1, 3);
    exp_tick(t + 6, 1'b0, 4);
    exp_tick(t + 7, 1'b1, 5);
    exp_tick(t + 8, 1'b0, 6);
    @(negedge clock);
    start = 1'b0;
    wait_until(t + 5);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    wait_until(t + 8);
    chk("div0_busy", int'(busy), 1);
    @(negedge clock);
    chk("div0_idle", int'(busy), 0);

    // burst limit of 3 at div 4
    @(negedge clock);
    t = cyc;
    cfg_div = 27'd4;
    cfg_burst = 8'd3;
    cfg_wr = 1'b1;
    aq.push_back(t + 1);
    @(negedge clock);
    cfg_wr = 1'b0;
    start = 1'b1;
    exp_tick(t + 6, 1'b1, 1);
    exp_tick(t + 10, 1'b0, 2);
    exp_tick(t + 14, 1'b1, 3);
    exp_tick(t + 18, 1'b0, 4);
    @(negedge clock);
    start = 1'b0;
`ifdef TIMEBASE_BURST_EN
    dq.push_back(t + 14);
    wait_until(t + 18);
    chk("burst_busy", int'(busy), 1);
    @(negedge clock);
    chk("burst_idle", int'(busy), 0);
    chk("burst_hz", int'(hzSig), 0);
`else
    exp_tick(t + 22, 1'b1, 5);
    wait_until(t + 19);
    chk("noburst_busy", int'(busy), 1);
    wait_until(t + 22);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("noburst_reset_busy", int'(busy), 0);
`endif

    repeat (4) @(negedge clock);
    chk("tick_left", tq.size(), 0);
    chk("ack_left", aq.size(), 0);
    chk("done_left", dq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
